pulse_arbiter: RTL and testbench
================================

PULSE_ARBITER -- requirements
Module: pulse_arbiter

Interface
REQ-001 The module SHALL have parameter CLK_HZ, default 27000000, meaning the clk frequency in Hz.
REQ-002 The module SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (legal range 2..8).
REQ-003 The module SHALL have parameter PULSE_DURATION_MS, default 1, meaning the pulse length in ms (legal range 1 and up).
REQ-004 The module SHALL have parameter GAP_MS, default 1, meaning the minimum low time in ms between pulses (legal range 0 and up).
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The module SHALL have port req_in, input, NUM_REQ bits: per-requester level inputs, synchronous to clk; a rising edge is a request.
REQ-008 The module SHALL have port pulse_out, output, 1 bit: the shared output pulse.
REQ-009 The module SHALL have port pulse_id, output, clog2(NUM_REQ) bits: the index of the requester owning the current or most recent pulse.
REQ-010 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The module SHALL have port pending, output, NUM_REQ bits: per-requester request-queued flags.
REQ-012 The module SHALL have port overrun, output, NUM_REQ bits: sticky per-requester lost-request flags.

Function
REQ-013 The module SHALL use PULSE_CYC = PULSE_DURATION_MS*(CLK_HZ/1000) and GAP_CYC = GAP_MS*(CLK_HZ/1000), each held in a 32-bit counter.
REQ-014 The module SHALL register req_in every cycle; edge[i] = req_in[i] & ~req_in_q[i].
REQ-015 An edge[i] at clk edge k SHALL set pending[i] at edge k.
REQ-016 An edge[i] while pending[i] is already 1 and not being granted in that cycle SHALL set overrun[i]; pending[i] SHALL stay 1, so only one request is queued per requester.
REQ-017 An edge[i] in the same cycle pending[i] is cleared by a grant SHALL leave pending[i] = 1 without setting overrun[i].
REQ-018 The FSM SHALL have exactly three states: IDLE, PULSE and GAP.
REQ-019 In IDLE with any pending bit set, the FSM SHALL grant the first pending index found by searching upward from last_grant+1 modulo NUM_REQ, then clear that pending bit, load pulse_id, set last_grant, assert pulse_out, load the counter with 0, and go to PULSE.
REQ-020 In PULSE, pulse_out SHALL stay high for exactly PULSE_CYC cycles; on the last cycle pulse_out SHALL deassert and the FSM SHALL go to GAP, or go straight to IDLE if GAP_CYC = 0.
REQ-021 In GAP, pulse_out SHALL stay low for exactly GAP_CYC cycles, then the FSM SHALL return to IDLE; a grant can happen no earlier than the cycle after IDLE is entered.
REQ-022 A request edge SHALL never retrigger or extend an active pulse; it only sets pending.
REQ-023 A requester whose edge lands at edge k while the FSM is IDLE and nothing else is pending SHALL see pulse_out rise at edge k+1.
REQ-024 pulse_id SHALL change only on a grant and SHALL hold its value through GAP and IDLE.
REQ-025 Bits of pending and overrun above NUM_REQ-1 SHALL NOT exist; all NUM_REQ bits SHALL update independently in the same cycle.

Reset
REQ-026 While rst is high, the module SHALL force state = IDLE, pulse_out = 0, busy = 0, pending = 0, overrun = 0, pulse_id = 0, counter = 0, req_in_q = 0, and last_grant = NUM_REQ-1 so that requester 0 has first priority.
REQ-027 Reset asserted mid-PULSE SHALL drop pulse_out asynchronously, with no completion of the pulse and no gap.
REQ-028 After rst deasserts, a req_in already high SHALL count as an edge in the first cycle, because req_in_q resets to 0.

Verification (CLK_HZ=4000, NUM_REQ=4, PULSE_DURATION_MS=2, GAP_MS=1 -> PULSE_CYC=8, GAP_CYC=4)
REQ-029 Single request: req_in[2] rises at edge 10 -> pending[2]=1 at 10; pulse_out high at edges 11..18, low at 19; pulse_id=2; busy low again from edge 23.
REQ-030 Simultaneous requests: req_in=4'b1111 rises at one edge right after reset -> pulses granted in order 0,1,2,3, each 8 high cycles separated by 4 low cycles; overrun=0.
REQ-031 Round robin: last_grant=1 with pending=4'b1011 in IDLE -> grant 3, then 0, then 1.
REQ-032 Overrun: two rising edges on req_in[1] while a pulse for requester 0 is active -> overrun[1]=1 sticky; exactly one pulse with pulse_id=1 follows.
REQ-033 Edge at grant: edge on req_in[0] in the same cycle requester 0 is granted -> pending[0] stays 1, overrun[0]=0, and a second pulse for 0 follows after the gap.
REQ-034 Reset mid-pulse: rst pulsed at pulse cycle 4 -> pulse_out=0 immediately and all outputs reach their reset values; with req_in[3] held high, the first grant after release is requester 3.

Source files
------------

// File: rtl/pulse_arbiter.sv
// pulse_arbiter: round-robin arbiter that shares one timed output pulse
// among NUM_REQ requesters. Each requester queues at most one request
// (a rising edge on its req_in bit); extra edges while queued are flagged
// as sticky overruns. Every pulse lasts PULSE_CYC cycles and is followed by
// GAP_CYC low cycles plus one IDLE cycle before the next grant.
module pulse_arbiter #(
  parameter int CLK_HZ            = 27000000,
  parameter int NUM_REQ           = 4,
  parameter int PULSE_DURATION_MS = 1,
  parameter int GAP_MS            = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_in,
  output logic                       pulse_out,
  output logic [$clog2(NUM_REQ)-1:0] pulse_id,
  output logic                       busy,
  output logic [NUM_REQ-1:0]         pending,
  output logic [NUM_REQ-1:0]         overrun
);

  localparam int              IDW       = $clog2(NUM_REQ);
  localparam logic [31:0]     PULSE_CYC = 32'(PULSE_DURATION_MS * (CLK_HZ / 1000));
  localparam logic [31:0]     GAP_CYC   = 32'(GAP_MS * (CLK_HZ / 1000));
  localparam logic [IDW:0]    NUM_REQ_W = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0]  LAST_RST  = IDW'(NUM_REQ - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] overrun_q, overrun_d;

  logic [NUM_REQ-1:0] edge_s;
  logic [NUM_REQ-1:0] grant_vec_s;
  logic               grant_found_s;
  logic               grant_s;
  logic [IDW-1:0]     grant_idx_s;
  logic [IDW:0]       scan_sum_s;

  // Rising edge of each request level against last cycle's sample.
  assign edge_s  = req_in & ~req_q;
  assign grant_s = (state_q == S_IDLE) && grant_found_s;

  // Round-robin scan: first pending index upward from last_grant+1, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    scan_sum_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_sum_s = {1'b0, last_q} + (IDW + 1)'(k);
      if (scan_sum_s >= NUM_REQ_W) begin
        scan_sum_s = scan_sum_s - NUM_REQ_W;
      end else begin
        scan_sum_s = scan_sum_s;
      end
      if (!grant_found_s && pending_q[scan_sum_s[IDW-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = scan_sum_s[IDW-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot of the requester being granted this cycle (empty when no grant).
  always_comb begin
    grant_vec_s = '0;
    if (grant_s) begin
      grant_vec_s[grant_idx_s] = 1'b1;
    end else begin
      grant_vec_s = '0;
    end
  end

  // Request queue: an edge always leaves the bit set; a second edge on a
  // still-queued, non-granted bit is recorded as a sticky overrun.
  always_comb begin
    pending_d = (pending_q & ~grant_vec_s) | edge_s;
    overrun_d = overrun_q | (edge_s & pending_q & ~grant_vec_s);
  end

  // Pulse sequencer: IDLE -> PULSE (PULSE_CYC cycles) -> GAP (GAP_CYC cycles).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (grant_s) begin
          id_d    = grant_idx_s;
          last_d  = grant_idx_s;
          pulse_d = 1'b1;
          cnt_d   = 32'd0;
          state_d = S_PULSE;
        end else begin
          pulse_d = 1'b0;
          cnt_d   = 32'd0;
        end
      end
      S_PULSE: begin
        if (cnt_q >= PULSE_CYC - 32'd1) begin
          pulse_d = 1'b0;
          cnt_d   = 32'd0;
          if (GAP_CYC == 32'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q >= GAP_CYC - 32'd1) begin
          cnt_d   = 32'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 32'd0;
        pulse_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers; reset drops the pulse immediately with no gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 32'd0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      id_q      <= '0;
      last_q    <= LAST_RST;
      req_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      id_q      <= id_d;
      last_q    <= last_d;
      req_q     <= req_in;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign pulse_out = pulse_q;
  assign pulse_id  = id_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pulse_arbiter.sv
// tb_pulse_arbiter: directed scenarios plus randomized traffic, checked
// every cycle against a timeline-based reference model of the arbiter.
module tb_pulse_arbiter;

  localparam int CLK_HZ  = 4000;
  localparam int NUM_REQ = 4;
  localparam int PDM     = 2;
  localparam int GAP_MS  = 1;
  localparam int P       = PDM * (CLK_HZ / 1000);
  localparam int G       = GAP_MS * (CLK_HZ / 1000);
  localparam int IDW     = $clog2(NUM_REQ);

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_REQ-1:0] req_in;
  logic               pulse_out;
  logic [IDW-1:0]     pulse_id;
  logic               busy;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] overrun;

  pulse_arbiter #(
    .CLK_HZ(CLK_HZ), .NUM_REQ(NUM_REQ),
    .PULSE_DURATION_MS(PDM), .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .pulse_out(pulse_out),
    .pulse_id(pulse_id), .busy(busy), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the arbiter as a timeline. A grant at edge g owns
  // pulse_out for edges [g, g+P), busy for [g, g+P+G), and the next grant
  // may happen at edge g+P+G+1 or later.
  int t = 0;
  int g_last;
  int m_last;
  int m_id;
  bit m_pend[NUM_REQ];
  bit m_ovr[NUM_REQ];
  bit m_prev[NUM_REQ];

  int   seen[$];
  logic prev_obs = 1'b0;
  int   hi_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d)", tag, got, exp, t);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    g_last = -1000;
    m_last = NUM_REQ - 1;
    m_id   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      m_pend[i] = 1'b0;
      m_ovr[i]  = 1'b0;
      m_prev[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [NUM_REQ-1:0] r);
    int gi;
    int c;
    t++;
    gi = -1;
    if (t >= g_last + P + G + 1) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (m_last + k) % NUM_REQ;
        if (gi < 0 && m_pend[c]) gi = c;
      end
    end
    if (gi >= 0) begin
      g_last     = t;
      m_last     = gi;
      m_id       = gi;
      m_pend[gi] = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r[i] && !m_prev[i]) begin
        if (m_pend[i]) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
      m_prev[i] = r[i];
    end
  endtask

  task automatic compare_all();
    logic [NUM_REQ-1:0] ep;
    logic [NUM_REQ-1:0] eo;
    for (int i = 0; i < NUM_REQ; i++) begin
      ep[i] = m_pend[i];
      eo[i] = m_ovr[i];
    end
    check("pulse_out", 32'(pulse_out), 32'((t >= g_last) && (t < g_last + P)));
    check("busy",      32'(busy),      32'((t >= g_last) && (t < g_last + P + G)));
    check("pulse_id",  32'(pulse_id),  32'(m_id));
    check("pending",   32'(pending),   32'(ep));
    check("overrun",   32'(overrun),   32'(eo));
  endtask

  task automatic step(input logic [NUM_REQ-1:0] r);
    req_in = r;
    @(posedge clk);
    model_edge(r);
    #1;
    compare_all();
    if (pulse_out && !prev_obs) seen.push_back(int'(pulse_id));
    if (pulse_out) hi_cnt++;
    prev_obs = pulse_out;
  endtask

  task automatic run(input logic [NUM_REQ-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  // Reset is raised mid-cycle so its asynchronous effect is visible at once.
  task automatic do_reset(input logic [NUM_REQ-1:0] r);
    req_in = r;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_obs = 1'b0;
    seen.delete();
    hi_cnt = 0;
  endtask

  task automatic check_seen(input string tag, input int n, input logic [15:0] ids);
    logic [3:0] e;
    check({tag, "_count"}, 32'(seen.size()), 32'(n));
    for (int k = 0; k < n; k++) begin
      e = ids[4*k +: 4];
      if (k < seen.size()) check({tag, "_id"}, 32'(seen[k]), 32'(e));
      else check({tag, "_missing"}, 32'd1, 32'd0);
    end
  endtask

  logic [NUM_REQ-1:0] rr;
  logic [NUM_REQ-1:0] msk;

  initial begin
    rst    = 1'b0;
    req_in = '0;
    #2;
    do_reset('0);

    // Single request on requester 2.
    run(4'b0000, 3);
    step(4'b0100);
    check("single_pend2", 32'(pending[2]), 32'd1);
    run(4'b0100, 20);
    check("single_high_cycles", 32'(hi_cnt), 32'(P));
    check_seen("single", 1, 16'h0002);

    // All four requesters at once: served 0,1,2,3.
    do_reset('0);
    step(4'b1111);
    run(4'b1111, 60);
    check("simul_overrun", 32'(overrun), 32'd0);
    check_seen("simul", 4, 16'h3210);

    // Round robin after last_grant=1 with 0,1,3 queued: 3, 0, 1.
    do_reset('0);
    step(4'b0010);
    step(4'b0000);
    step(4'b1011);
    run(4'b0000, 50);
    check_seen("rr", 4, 16'h1031);

    // Overrun: two edges on requester 1 during requester 0's pulse.
    do_reset('0);
    step(4'b0001);
    step(4'b0000);
    step(4'b0010);
    step(4'b0000);
    step(4'b0010);
    run(4'b0000, 30);
    check("ovr_bit1", 32'(overrun[1]), 32'd1);
    check_seen("ovr", 2, 16'h0010);

    // Edge on requester 0 exactly when it is granted.
    do_reset('0);
    step(4'b0010);
    step(4'b0011);
    while (t < g_last + P + G) step(4'b0000);
    step(4'b0001);
    check("edge_at_grant_pend0", 32'(pending[0]), 32'd1);
    check("edge_at_grant_ovr0", 32'(overrun[0]), 32'd0);
    run(4'b0001, 40);
    check_seen("edge_at_grant", 3, 16'h0001);

    // Reset at pulse cycle 4 with requester 3 held high.
    do_reset('0);
    step(4'b0001);
    step(4'b1000);
    run(4'b1000, 3);
    check("midreset_pre_pulse", 32'(pulse_out), 32'd1);
    do_reset(4'b1000);
    check("midreset_pulse_low", 32'(pulse_out), 32'd0);
    run(4'b1000, 20);
    check_seen("midreset", 1, 16'h0003);

    // Randomized traffic with occasional resets.
    do_reset('0);
    rr = '0;
    for (int c = 0; c < 3000; c++) begin
      msk = '0;
      for (int i = 0; i < NUM_REQ; i++) msk[i] = ($urandom_range(0, 5) == 0);
      rr = rr ^ msk;
      if ($urandom_range(0, 499) == 0) do_reset(rr);
      else step(rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
